stereo_camera_emulator: RTL and testbench

- Synthesisable source for the interleaved stereo camera stream (`frame_valid`, `line_valid`, `pixel_data`) that the camera front end consumes.
- Used in place of the physical sensor pair, for bring-up and regression of the disparity pipeline.
- Generates deterministic left/right test images; the right image is a copy of the left shifted by a programmable disparity.
- Depth output is therefore known in advance for every pixel.

---
 rtl/stereo_camera_emulator_if.sv | 25 ++
 rtl/stereo_camera_emulator.sv | 199 +++++++++++++++++++
 tb/tb_stereo_camera_emulator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/stereo_camera_emulator_if.sv
// Interleaved stereo video stream as driven by the camera emulator and
// consumed by the camera front end.
interface stereo_camera_emulator_if;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pixel_data;
    logic        frame_done;
    logic [15:0] frame_count;

    modport master (
        output frame_valid,
        output line_valid,
        output pixel_data,
        output frame_done,
        output frame_count
    );

    modport slave (
        input frame_valid,
        input line_valid,
        input pixel_data,
        input frame_done,
        input frame_count
    );
endinterface

// File: rtl/stereo_camera_emulator.sv
// Deterministic stereo sensor-pair stand-in: emits left/right byte-interleaved
// test images where the right image is the left one shifted by a set disparity.
module stereo_camera_emulator #(
    parameter int H_ACTIVE = 752,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 94,
    parameter int V_BLANK  = 1000,
    parameter int FV_TO_LV = 4,
    parameter int LV_TO_FV = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                pattern_sel,
    input  logic [5:0]                disparity,
    stereo_camera_emulator_if.master  vid
);

    localparam logic [15:0] LEAD_LAST  = 16'(FV_TO_LV - 1);
    localparam logic [15:0] LINE_LAST  = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] HBL_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] TRAIL_LAST = 16'(LV_TO_FV - 1);
    localparam logic [15:0] VBL_LAST   = 16'(V_BLANK - 1);
    localparam logic [8:0]  Y_LAST     = 9'(V_ACTIVE - 1);
    localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FV_LEAD  = 3'd1,
        LINE     = 3'd2,
        HBLANK   = 3'd3,
        FV_TRAIL = 3'd4,
        VBLANK   = 3'd5
    } state_t;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [8:0]  y_r;
    logic [1:0]  mode_r;
    logic [5:0]  disp_r;
    logic        frame_valid_r;
    logic        line_valid_r;
    logic [7:0]  pixel_data_r;
    logic        frame_done_r;
    logic [15:0] frame_count_r;

    logic [10:0] byte_idx_s;
    logic [9:0]  x_s;
    logic [10:0] x_shift_s;
    logic [7:0]  y_next_s;
    logic [7:0]  pixel_next_s;

    function automatic logic [7:0] pattern_px(input logic [1:0] mode,
                                              input logic [7:0] x,
                                              input logic [7:0] y);
        logic [7:0] px;
        case (mode)
            2'd0:    px = x;
            2'd1:    px = y;
            2'd2:    px = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            2'd3:    px = x * 8'd37 + y * 8'd101;
            default: px = 8'h00;
        endcase
        return px;
    endfunction

    // Byte to present on the next edge; outputs are registered, so look one byte ahead.
    always_comb begin
        byte_idx_s   = 11'd0;
        y_next_s     = y_r[7:0];
        pixel_next_s = 8'h00;
        if (state_r == LINE) begin
            byte_idx_s = cnt_r[10:0] + 11'd1;
        end else begin
            byte_idx_s = 11'd0;
        end
        if (state_r == HBLANK) begin
            y_next_s = y_r[7:0] + 8'd1;
        end else begin
            y_next_s = y_r[7:0];
        end
        x_s       = byte_idx_s[10:1];
        x_shift_s = {1'b0, x_s} + {5'd0, disp_r};
        if (!byte_idx_s[0]) begin
            pixel_next_s = pattern_px(mode_r, x_s[7:0], y_next_s);
        end else if (x_shift_s < H_LIM) begin
            pixel_next_s = pattern_px(mode_r, x_shift_s[7:0], y_next_s);
        end else begin
            pixel_next_s = 8'h00;
        end
    end

    // Frame timing FSM with registered stream outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= 16'd0;
            y_r           <= 9'd0;
            mode_r        <= 2'd0;
            disp_r        <= 6'd0;
            frame_valid_r <= 1'b0;
            line_valid_r  <= 1'b0;
            pixel_data_r  <= 8'h00;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        state_r       <= FV_LEAD;
                        cnt_r         <= 16'd0;
                        y_r           <= 9'd0;
                        mode_r        <= pattern_sel;
                        disp_r        <= disparity;
                        frame_valid_r <= 1'b1;
                    end else begin
                        frame_valid_r <= 1'b0;
                    end
                    line_valid_r <= 1'b0;
                    pixel_data_r <= 8'h00;
                end
                FV_LEAD: begin
                    if (cnt_r == LEAD_LAST) begin
                        state_r      <= LINE;
                        cnt_r        <= 16'd0;
                        line_valid_r <= 1'b1;
                        pixel_data_r <= pixel_next_s;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                LINE: begin
                    if (cnt_r == LINE_LAST) begin
                        state_r      <= (y_r < Y_LAST) ? HBLANK : FV_TRAIL;
                        cnt_r        <= 16'd0;
                        line_valid_r <= 1'b0;
                        pixel_data_r <= 8'h00;
                    end else begin
                        cnt_r        <= cnt_r + 16'd1;
                        pixel_data_r <= pixel_next_s;
                    end
                end
                HBLANK: begin
                    if (cnt_r == HBL_LAST) begin
                        state_r      <= LINE;
                        cnt_r        <= 16'd0;
                        y_r          <= y_r + 9'd1;
                        line_valid_r <= 1'b1;
                        pixel_data_r <= pixel_next_s;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                FV_TRAIL: begin
                    if (cnt_r == TRAIL_LAST) begin
                        state_r       <= VBLANK;
                        cnt_r         <= 16'd0;
                        frame_valid_r <= 1'b0;
                        frame_done_r  <= 1'b1;
                        frame_count_r <= frame_count_r + 16'd1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                VBLANK: begin
                    if (cnt_r == VBL_LAST) begin
                        cnt_r <= 16'd0;
                        y_r   <= 9'd0;
                        if (enable) begin
                            state_r       <= FV_LEAD;
                            mode_r        <= pattern_sel;
                            disp_r        <= disparity;
                            frame_valid_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= 16'd0;
                    frame_valid_r <= 1'b0;
                    line_valid_r  <= 1'b0;
                    pixel_data_r  <= 8'h00;
                end
            endcase
        end
    end

    assign vid.frame_valid = frame_valid_r;
    assign vid.line_valid  = line_valid_r;
    assign vid.pixel_data  = pixel_data_r;
    assign vid.frame_done  = frame_done_r;
    assign vid.frame_count = frame_count_r;

endmodule

// File: tb/tb_stereo_camera_emulator.sv
// Directed bench for stereo_camera_emulator on a 4x2 image: frame timing,
// pattern/disparity bytes, input latching, enable drop and mid-frame reset.
module tb_stereo_camera_emulator;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [5:0] disparity;
    int         compared   = 0;
    int         mismatched = 0;

    // Expected line bytes, first byte in the top octet.
    localparam logic [63:0] L_M0_D0 = 64'h0000010102020303;
    localparam logic [63:0] L_M0_D1 = 64'h0001010202030300;
    localparam logic [63:0] L_M0_D5 = 64'h0000010002000300;
    localparam logic [63:0] L_M3_Y0 = 64'h000025254A4A6F6F;
    localparam logic [63:0] L_M3_Y1 = 64'h65658A8AAFAFD4D4;
    localparam logic [63:0] L_M3D1Y0 = 64'h0025254A4A6F6F00;
    localparam logic [63:0] L_M3D1Y1 = 64'h658A8AAFAFD4D400;

    stereo_camera_emulator_if vif ();

    stereo_camera_emulator #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3),
        .V_BLANK(5), .FV_TO_LV(2), .LV_TO_FV(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .disparity   (disparity),
        .vid         (vif)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic [15:0] cnt);
        chk({tag, " fv"},    32'(vif.frame_valid), 32'd0);
        chk({tag, " lv"},    32'(vif.line_valid),  32'd0);
        chk({tag, " pix"},   32'(vif.pixel_data),  32'd0);
        chk({tag, " done"},  32'(vif.frame_done),  32'd0);
        chk({tag, " count"}, 32'(vif.frame_count), 32'(cnt));
    endtask

    // Walks 28 cycles from the first frame_valid-high cycle; optionally
    // changes inputs after the checks of cycle chg_at.
    task automatic check_frame(input string tag, input logic [63:0] l0, input logic [63:0] l1,
                               input logic [15:0] cnt0, input int chg_at,
                               input logic [1:0] n_sel, input logic [5:0] n_d, input logic n_en);
        for (int c = 0; c < 28; c++) begin
            logic       e_fv;
            logic       e_lv;
            logic [7:0] e_pix;
            logic [15:0] e_cnt;
            e_fv  = (c < 23);
            e_lv  = (c >= 2 && c < 10) || (c >= 13 && c < 21);
            e_pix = 8'h00;
            if (c >= 2 && c < 10)  e_pix = l0[63 - 8 * (c - 2)  -: 8];
            if (c >= 13 && c < 21) e_pix = l1[63 - 8 * (c - 13) -: 8];
            e_cnt = (c >= 23) ? cnt0 + 16'd1 : cnt0;
            chk($sformatf("%s fv c%0d", tag, c),    32'(vif.frame_valid), 32'(e_fv));
            chk($sformatf("%s lv c%0d", tag, c),    32'(vif.line_valid),  32'(e_lv));
            chk($sformatf("%s pix c%0d", tag, c),   32'(vif.pixel_data),  32'(e_pix));
            chk($sformatf("%s done c%0d", tag, c),  32'(vif.frame_done),  32'(c == 23));
            chk($sformatf("%s count c%0d", tag, c), 32'(vif.frame_count), 32'(e_cnt));
            if (c == chg_at) begin
                pattern_sel = n_sel;
                disparity   = n_d;
                enable      = n_en;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        disparity   = 6'd0;
        @(negedge clock);
        chk_quiet("reset", 16'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_quiet("idle", 16'd0);

        enable = 1'b1;
        @(negedge clock);
        check_frame("m0d0", L_M0_D0, L_M0_D0, 16'd0, 24, 2'd0, 6'd1, 1'b1);
        check_frame("m0d1", L_M0_D1, L_M0_D1, 16'd1, 24, 2'd0, 6'd5, 1'b1);
        check_frame("m0d5", L_M0_D5, L_M0_D5, 16'd2, 24, 2'd3, 6'd0, 1'b1);
        // disparity changes during line 0: this frame keeps d=0
        check_frame("m3d0", L_M3_Y0, L_M3_Y1, 16'd3, 5, 2'd3, 6'd1, 1'b1);
        // enable dropped during line 0: frame still completes
        check_frame("m3d1", L_M3D1Y0, L_M3D1Y1, 16'd4, 5, 2'd0, 6'd0, 1'b0);
        repeat (3) begin
            chk_quiet("after_drop", 16'd5);
            @(negedge clock);
        end

        enable = 1'b1;
        repeat (5) @(negedge clock);
        chk("pre_reset lv",  32'(vif.line_valid), 32'd1);
        chk("pre_reset pix", 32'(vif.pixel_data), 32'd1);
        reset = 1'b1;
        #1;
        chk_quiet("async_reset", 16'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_frame("post_reset", L_M0_D0, L_M0_D0, 16'd0, 5, 2'd0, 6'd0, 1'b0);
        repeat (3) begin
            chk_quiet("final_idle", 16'd1);
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
